// File: rtl/axi_lite_reg_slv.sv
// axi_lite_reg_slv -- AXI4-Lite subordinate with a bank of NoRegs registers.
//   Registers are AXI-writable with per-byte strobes (unless marked ReadOnly),
//   hardware-loadable (load beats a same-cycle AXI write), and presented flat
//   on reg_q_o. reg_wr_o pulses for one cycle per register updated over AXI.
// Ports:
//   clk_i, rst_ni       clock, async active-low reset
//   axi_req_i/axi_rsp_o AXI4-Lite request / response structs
//   reg_load_i, reg_d_i per-register hardware load enable / data
//   reg_q_o             register contents
//   reg_wr_o            per-register AXI write notification pulse

package axi_lite_reg_slv_pkg;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  typedef struct packed { logic [31:0] addr; } ax_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; } w_t;
  typedef struct packed { logic [1:0] resp; } b_t;
  typedef struct packed { logic [31:0] data; logic [1:0] resp; } r_t;

  typedef struct packed {
    ax_t  aw;
    logic aw_valid;
    w_t   w;
    logic w_valid;
    logic b_ready;
    ax_t  ar;
    logic ar_valid;
    logic r_ready;
  } req_t;

  typedef struct packed {
    logic aw_ready;
    logic w_ready;
    b_t   b;
    logic b_valid;
    logic ar_ready;
    r_t   r;
    logic r_valid;
  } rsp_t;
endpackage

module axi_lite_reg_slv
  import axi_lite_reg_slv_pkg::*;
#(
  parameter int unsigned NoRegs    = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter logic [NoRegs-1:0]                ReadOnly = '0,
  parameter logic [NoRegs-1:0][DataWidth-1:0] RstVal   = '0,
  parameter type axi_lite_req_t = axi_lite_reg_slv_pkg::req_t,
  parameter type axi_lite_rsp_t = axi_lite_reg_slv_pkg::rsp_t
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  axi_lite_req_t                      axi_req_i,
  output axi_lite_rsp_t                      axi_rsp_o,
  input  logic [NoRegs-1:0]                  reg_load_i,
  input  logic [NoRegs-1:0][DataWidth-1:0]   reg_d_i,
  output logic [NoRegs-1:0][DataWidth-1:0]   reg_q_o,
  output logic [NoRegs-1:0]                  reg_wr_o
);
  localparam int unsigned StrbW = DataWidth / 8;
  localparam int unsigned OffW  = $clog2(StrbW);

  typedef enum logic { WrIdle, WrBresp } wr_state_e;
  typedef enum logic { RdIdle, RdRresp } rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic [NoRegs-1:0][DataWidth-1:0] reg_q;
  logic [NoRegs-1:0]                reg_wr_q;
  logic [1:0]                       b_resp_q, wr_resp;
  logic [DataWidth-1:0]             r_data_q, rd_data_sel;
  logic [1:0]                       r_resp_q;

  logic [AddrWidth-1:0] aw_word, ar_word;
  logic [NoRegs-1:0]    wr_sel, rd_sel;
  logic                 wr_hs, rd_hs, wr_ok;
  logic [DataWidth-1:0] wr_old, wr_new;

  // Word index over the full address width: any set upper bit decodes to
  // out of range rather than aliasing onto a register.
  assign aw_word = axi_req_i.aw.addr >> OffW;
  assign ar_word = axi_req_i.ar.addr >> OffW;

  // AW and W are only ever taken together.
  assign wr_hs = (wr_state_q == WrIdle) && axi_req_i.aw_valid && axi_req_i.w_valid;
  assign rd_hs = (rd_state_q == RdIdle) && axi_req_i.ar_valid;

  always_comb begin
    wr_sel      = '0;
    rd_sel      = '0;
    wr_old      = '0;
    rd_data_sel = '0;  // stays 0 for an out-of-range read
    for (int i = 0; i < NoRegs; i++) begin
      wr_sel[i] = (aw_word == AddrWidth'(i));
      rd_sel[i] = (ar_word == AddrWidth'(i));
      if (wr_sel[i]) wr_old = reg_q[i];
      if (rd_sel[i]) rd_data_sel = reg_q[i];
    end
  end

  always_comb begin
    wr_new = wr_old;
    for (int b = 0; b < StrbW; b++)
      if (axi_req_i.w.strb[b]) wr_new[b*8 +: 8] = axi_req_i.w.data[b*8 +: 8];
  end

  always_comb begin
    wr_resp = RespOkay;
    wr_ok   = 1'b0;
    if (wr_sel == '0)               wr_resp = RespDecErr;
    else if ((wr_sel & ReadOnly) != '0) wr_resp = RespSlvErr;
    else                            wr_ok   = wr_hs;
  end

  // Next-state logic for both channel FSMs.
  always_comb begin
    wr_state_d = wr_state_q;
    rd_state_d = rd_state_q;
    case (wr_state_q)
      WrIdle:  if (wr_hs) wr_state_d = WrBresp;
      WrBresp: if (axi_req_i.b_ready) wr_state_d = WrIdle;
      default: wr_state_d = WrIdle;
    endcase
    case (rd_state_q)
      RdIdle:  if (rd_hs) rd_state_d = RdRresp;
      RdRresp: if (axi_req_i.r_ready) rd_state_d = RdIdle;
      default: rd_state_d = RdIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_state_q <= WrIdle;
      rd_state_q <= RdIdle;
      b_resp_q   <= '0;
      r_data_q   <= '0;
      r_resp_q   <= '0;
      reg_wr_q   <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      reg_wr_q   <= wr_ok ? wr_sel : '0;
      if (wr_hs) b_resp_q <= wr_resp;
      if (rd_hs) begin
        r_data_q <= rd_data_sel;  // pre-edge contents
        r_resp_q <= (rd_sel != '0) ? RespOkay : RespDecErr;
      end
    end
  end

  // Hardware load takes priority over a same-cycle AXI write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_q <= RstVal;
    end else begin
      for (int i = 0; i < NoRegs; i++) begin
        if (reg_load_i[i])           reg_q[i] <= reg_d_i[i];
        else if (wr_ok && wr_sel[i]) reg_q[i] <= wr_new;
      end
    end
  end

  always_comb begin
    axi_rsp_o          = '0;
    axi_rsp_o.aw_ready = wr_hs;
    axi_rsp_o.w_ready  = wr_hs;
    axi_rsp_o.b_valid  = (wr_state_q == WrBresp);
    axi_rsp_o.b.resp   = b_resp_q;
    axi_rsp_o.ar_ready = (rd_state_q == RdIdle);
    axi_rsp_o.r_valid  = (rd_state_q == RdRresp);
    axi_rsp_o.r.data   = r_data_q;
    axi_rsp_o.r.resp   = r_resp_q;
  end

  assign reg_q_o  = reg_q;
  assign reg_wr_o = reg_wr_q;

endmodule

// File: tb/tb_axi_lite_reg_slv.sv
// tb_axi_lite_reg_slv -- scoreboard bench for axi_lite_reg_slv.
//   A transaction-level model (register array + outstanding-response flags)
//   predicts B/R responses into queues; a negedge monitor compares the DUT's
//   outputs against the model and pops the queues on each B/R handshake.
module tb_axi_lite_reg_slv;
  import axi_lite_reg_slv_pkg::*;

  localparam int NR = 4;
  localparam logic [NR-1:0] RO = 4'b0001;
  localparam logic [NR-1:0][31:0] RST_VAL =
    {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  req_t req = '0;
  rsp_t rsp;
  logic [NR-1:0]        load = '0;
  logic [NR-1:0][31:0]  dload = '0;
  logic [NR-1:0][31:0]  q;
  logic [NR-1:0]        wr;

  axi_lite_reg_slv #(
    .NoRegs(NR), .AddrWidth(32), .DataWidth(32),
    .ReadOnly(RO), .RstVal(RST_VAL),
    .axi_lite_req_t(req_t), .axi_lite_rsp_t(rsp_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .axi_req_i(req), .axi_rsp_o(rsp),
    .reg_load_i(load), .reg_d_i(dload), .reg_q_o(q), .reg_wr_o(wr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0]   mreg [NR];
  logic          b_pend = 1'b0, r_pend = 1'b0;
  logic [NR-1:0] exp_wr = '0;
  logic          last_wr_hs = 1'b0, last_rd_hs = 1'b0;
  logic [1:0]    bq [$];
  rexp_t         rq [$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < NR; i++) mreg[i] = RST_VAL[i];
    b_pend = 1'b0; r_pend = 1'b0; exp_wr = '0;
    last_wr_hs = 1'b0; last_rd_hs = 1'b0;
    bq.delete(); rq.delete();
  endtask

  // Apply the effect of the clock edge that just passed, given the inputs
  // that were presented during the preceding cycle.
  task automatic model_edge();
    logic [31:0] old [NR];
    logic [31:0] idx;
    logic wr_hs, rd_hs;
    rexp_t re;
    if (!rst_n) begin reset_model(); return; end
    for (int i = 0; i < NR; i++) old[i] = mreg[i];
    wr_hs = !b_pend && req.aw_valid && req.w_valid;
    rd_hs = !r_pend && req.ar_valid;
    exp_wr = '0;
    if (rd_hs) begin
      idx = req.ar.addr / 4;
      if (idx < NR) begin re.data = old[idx]; re.resp = RespOkay; end
      else          begin re.data = '0;       re.resp = RespDecErr; end
      rq.push_back(re);
    end
    if (wr_hs) begin
      idx = req.aw.addr / 4;
      if (idx >= NR)   bq.push_back(RespDecErr);
      else if (RO[idx]) bq.push_back(RespSlvErr);
      else begin
        for (int b = 0; b < 4; b++)
          if (req.w.strb[b]) mreg[idx][b*8 +: 8] = req.w.data[b*8 +: 8];
        exp_wr[idx] = 1'b1;
        bq.push_back(RespOkay);
      end
    end
    for (int i = 0; i < NR; i++) if (load[i]) mreg[i] = dload[i];
    b_pend = (b_pend && !req.b_ready) || wr_hs;
    r_pend = (r_pend && !req.r_ready) || rd_hs;
    last_wr_hs = wr_hs;
    last_rd_hs = rd_hs;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    model_edge();
  endtask

  // Monitor: compares DUT against the model away from the active edge.
  always @(negedge clk) begin
    check("aw_ready", rsp.aw_ready, !b_pend && req.aw_valid && req.w_valid);
    check("w_ready",  rsp.w_ready,  !b_pend && req.aw_valid && req.w_valid);
    check("ar_ready", rsp.ar_ready, !r_pend);
    check("b_valid",  rsp.b_valid,  b_pend);
    check("r_valid",  rsp.r_valid,  r_pend);
    check("reg_wr",   wr, exp_wr);
    for (int i = 0; i < NR; i++) check($sformatf("reg_q[%0d]", i), q[i], mreg[i]);
    if (rsp.b_valid) begin
      if (bq.size() == 0) check("b_unexpected", 1, 0);
      else begin
        check("b_resp", rsp.b.resp, bq[0]);
        if (req.b_ready) void'(bq.pop_front());
      end
    end
    if (rsp.r_valid) begin
      if (rq.size() == 0) check("r_unexpected", 1, 0);
      else begin
        check("r_data", rsp.r.data, rq[0].data);
        check("r_resp", rsp.r.resp, rq[0].resp);
        if (req.r_ready) void'(rq.pop_front());
      end
    end
  end

  task automatic wr_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req.aw.addr = a; req.w.data = d; req.w.strb = s;
    req.aw_valid = 1'b1; req.w_valid = 1'b1; req.b_ready = 1'b1;
    tick();
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    tick();
  endtask

  task automatic rd_txn(input logic [31:0] a);
    req.ar.addr = a; req.ar_valid = 1'b1; req.r_ready = 1'b1;
    tick();
    req.ar_valid = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 15) == 0) return $urandom();
    return ($urandom_range(0, 6) << 2) | $urandom_range(0, 3);
  endfunction

  task automatic rand_inputs();
    if (!req.aw_valid || last_wr_hs) begin
      req.aw_valid = $urandom_range(0, 1); req.aw.addr = rand_addr();
    end
    if (!req.w_valid || last_wr_hs) begin
      req.w_valid = $urandom_range(0, 1); req.w.data = $urandom(); req.w.strb = 4'($urandom());
    end
    if (!req.ar_valid || last_rd_hs) begin
      req.ar_valid = $urandom_range(0, 1); req.ar.addr = rand_addr();
    end
    req.b_ready = ($urandom_range(0, 3) != 0);
    req.r_ready = ($urandom_range(0, 3) != 0);
    load = ($urandom_range(0, 7) == 0) ? NR'($urandom()) : '0;
    for (int i = 0; i < NR; i++) dload[i] = $urandom();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_model();
    repeat (3) tick();
    check("rst_b_valid", rsp.b_valid, 0);
    check("rst_r_valid", rsp.r_valid, 0);
    check("rst_ar_ready", rsp.ar_ready, 1);
    check("rst_r_data", rsp.r.data, 0);
    for (int i = 0; i < NR; i++) check("rst_q", q[i], RST_VAL[i]);
    rst_n = 1'b1;

    // Full write then read back, with latency and pulse checks.
    req.aw.addr = 32'h8; req.w.data = 32'hDEADBEEF; req.w.strb = 4'hF;
    req.aw_valid = 1'b1; req.w_valid = 1'b1; req.b_ready = 1'b1;
    tick();
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    check("wr_pulse_n1", wr, 4'b0100);
    check("b_valid_n1", rsp.b_valid, 1);
    check("q2_n1", q[2], 32'hDEADBEEF);
    tick();
    check("wr_pulse_n2", wr, 4'b0000);
    rd_txn(32'h8);

    // Byte strobes.
    wr_txn(32'h4, 32'h11223344, 4'hF);
    wr_txn(32'h5, 32'hAABBCCDD, 4'h5);
    check("strb_reg1", q[1], 32'h11BB33DD);

    // Read-only and out-of-range.
    wr_txn(32'h0, 32'hFFFFFFFF, 4'hF);
    check("ro_reg0", q[0], RST_VAL[0]);
    rd_txn(32'h10);
    wr_txn(32'h10, 32'h12345678, 4'hF);

    // Lone AW for three cycles, then W arrives; then B backpressure.
    req.aw.addr = 32'hC; req.w.data = 32'h0BAD_F00D; req.w.strb = 4'hF;
    req.aw_valid = 1'b1; req.b_ready = 1'b0;
    repeat (3) tick();
    req.w_valid = 1'b1; #1;
    check("join_aw_ready", rsp.aw_ready, 1);
    tick();
    req.w.data = 32'h7777_7777;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_aw_ready", rsp.aw_ready, 0);
      check("bp_b_valid", rsp.b_valid, 1);
    end
    req.b_ready = 1'b1;
    tick();
    tick();
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    tick();
    tick();

    // Same-cycle hardware load, AXI write and read of register 2.
    load[2] = 1'b1; dload[2] = 32'h55;
    req.aw.addr = 32'h8; req.w.data = 32'h99; req.w.strb = 4'hF;
    req.aw_valid = 1'b1; req.w_valid = 1'b1; req.b_ready = 1'b1;
    req.ar.addr = 32'h8; req.ar_valid = 1'b1; req.r_ready = 1'b1;
    tick();
    load = '0; req.aw_valid = 1'b0; req.w_valid = 1'b0; req.ar_valid = 1'b0;
    check("load_wins", q[2], 32'h55);
    check("load_wr_pulse", wr, 4'b0100);
    tick();

    // Reset while a read response is pending.
    req.ar.addr = 32'h4; req.ar_valid = 1'b1; req.r_ready = 1'b0;
    tick();
    req.ar_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_r_valid", rsp.r_valid, 0);
    for (int i = 0; i < NR; i++) check("arst_q", q[i], RST_VAL[i]);
    reset_model();
    tick();
    rst_n = 1'b1; req.r_ready = 1'b1;
    tick();

    // Randomised traffic.
    for (int n = 0; n < 1500; n++) begin
      rand_inputs();
      tick();
    end

    // Drain and confirm every predicted response was seen.
    req.aw_valid = 1'b0; req.w_valid = 1'b0; req.ar_valid = 1'b0;
    req.b_ready = 1'b1; req.r_ready = 1'b1; load = '0;
    repeat (4) tick();
    check("bq_empty", bq.size(), 0);
    check("rq_empty", rq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
